// File: rtl/gfx_fade_rmw.sv
// -----------------------------------------------------------------------------
// gfx_fade_rmw
//
// Read-modify-write fade engine for multi-channel pixel streams. Sits between
// the framebuffer read-back stream and the SRAM write-back path. Each accepted
// (address, pixel) beat is decayed per channel on fade frames and emitted with
// a write-needed flag so unchanged pixels can skip the SRAM write.
//
// Two-stage pipeline (stage 1 capture, stage 2 compute + output register),
// valid/ready on both sides, at most two beats buffered.
//
// Optional build macro: GFX_FADE_RMW_STATS_EN
//   defined   -> lit_count reports nonzero pixels emitted during the last frame
//   undefined -> lit_count is tied to 0
//
// Ports:
//   clk        in   sole clock
//   reset      in   asynchronous, active-low reset
//   mode       in   0 = linear decay, 1 = proportional decay (used in stage 2)
//   frame_tick in   single-cycle frame boundary strobe
//   s_valid    in   / s_ready out : input handshake
//   s_addr     in   [ADDR_BITS]          input beat address
//   s_pixel    in   [CHANNELS*CHAN_BITS] input beat pixel
//   m_valid    out  / m_ready in  : output handshake
//   m_addr     out  [ADDR_BITS]          pass-through address
//   m_pixel    out  [CHANNELS*CHAN_BITS] faded pixel
//   m_write    out  1 when m_pixel differs from the input pixel
//   lit_count  out  [ADDR_BITS+1]        nonzero pixels emitted last frame
// -----------------------------------------------------------------------------
module gfx_fade_rmw #(
   parameter int CHANNELS    = 3,
   parameter int CHAN_BITS   = 4,
   parameter int ADDR_BITS   = 20,
   parameter int DECAY_STEP  = 1,
   parameter int DECAY_SHIFT = 2,
   parameter int PERIOD      = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            mode,
   input  logic                            frame_tick,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [ADDR_BITS-1:0]            s_addr,
   input  logic [CHANNELS*CHAN_BITS-1:0]   s_pixel,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [ADDR_BITS-1:0]            m_addr,
   output logic [CHANNELS*CHAN_BITS-1:0]   m_pixel,
   output logic                            m_write,
   output logic [ADDR_BITS:0]              lit_count
);

   localparam int PIX     = CHANNELS * CHAN_BITS;
   localparam int PH_BITS = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PH_BITS-1:0] PH_LAST = PH_BITS'(PERIOD - 1);
   // Linear step at CHAN_BITS+1 bits; any step >= full scale simply clears.
   localparam logic [CHAN_BITS:0] STEP_W =
      (DECAY_STEP >= (1 << CHAN_BITS)) ? (CHAN_BITS+1)'(1 << CHAN_BITS)
                                       : (CHAN_BITS+1)'(DECAY_STEP);

   // Per-channel decay; subtraction is clamped at zero so nothing wraps.
   function automatic logic [PIX-1:0] fade_pixel(input logic [PIX-1:0] pix,
                                                 input logic           prop);
      logic [PIX-1:0]     res;
      logic [CHAN_BITS:0] v;
      logic [CHAN_BITS:0] d;
      res = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         v = {1'b0, pix[c*CHAN_BITS +: CHAN_BITS]};
         if (prop) begin
            d = v >> DECAY_SHIFT;
            // Small nonzero values still move towards black.
            if (d == '0 && v != '0) d = (CHAN_BITS+1)'(1);
         end else begin
            d = STEP_W;
         end
         if (v > d) res[c*CHAN_BITS +: CHAN_BITS] = CHAN_BITS'(v - d);
         else       res[c*CHAN_BITS +: CHAN_BITS] = '0;
      end
      return res;
   endfunction

   logic [PH_BITS-1:0]   phase_q, phase_d;
   logic                 st1_valid_q, st1_valid_d;
   logic [ADDR_BITS-1:0] st1_addr_q, st1_addr_d;
   logic [PIX-1:0]       st1_pix_q, st1_pix_d;
   logic                 st1_fade_q, st1_fade_d;
   logic                 m_valid_q, m_valid_d;
   logic [ADDR_BITS-1:0] m_addr_q, m_addr_d;
   logic [PIX-1:0]       m_pixel_q, m_pixel_d;
   logic                 m_write_q, m_write_d;
   logic                 st2_adv, st1_adv, fade_en;
   logic [PIX-1:0]       faded;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      phase_d     = phase_q;
      st1_valid_d = st1_valid_q;
      st1_addr_d  = st1_addr_q;
      st1_pix_d   = st1_pix_q;
      st1_fade_d  = st1_fade_q;
      m_valid_d   = m_valid_q;
      m_addr_d    = m_addr_q;
      m_pixel_d   = m_pixel_q;
      m_write_d   = m_write_q;

      fade_en = (phase_q == '0);
      if (frame_tick) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

      st2_adv = !m_valid_q || m_ready;
      st1_adv = !st1_valid_q || st2_adv;
      // Combinational from m_ready: a draining output frees stage 1 this cycle.
      s_ready = st1_adv;

      // Beat accepted alongside frame_tick takes the pre-tick fade_en.
      if (st1_adv) begin
         st1_valid_d = s_valid;
         if (s_valid) begin
            st1_addr_d = s_addr;
            st1_pix_d  = s_pixel;
            st1_fade_d = fade_en;
         end
      end

      faded = st1_fade_q ? fade_pixel(st1_pix_q, mode) : st1_pix_q;
      if (st2_adv) begin
         m_valid_d = st1_valid_q;
         if (st1_valid_q) begin
            m_addr_d  = st1_addr_q;
            m_pixel_d = faded;
            m_write_d = (faded != st1_pix_q);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q     <= '0;
         st1_valid_q <= 1'b0;
         st1_addr_q  <= '0;
         st1_pix_q   <= '0;
         st1_fade_q  <= 1'b0;
         m_valid_q   <= 1'b0;
         m_addr_q    <= '0;
         m_pixel_q   <= '0;
         m_write_q   <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         st1_valid_q <= st1_valid_d;
         st1_addr_q  <= st1_addr_d;
         st1_pix_q   <= st1_pix_d;
         st1_fade_q  <= st1_fade_d;
         m_valid_q   <= m_valid_d;
         m_addr_q    <= m_addr_d;
         m_pixel_q   <= m_pixel_d;
         m_write_q   <= m_write_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_addr  = m_addr_q;
   assign m_pixel = m_pixel_q;
   assign m_write = m_write_q;

`ifdef GFX_FADE_RMW_STATS_EN
   logic [ADDR_BITS:0] cnt_q, cnt_d;
   logic [ADDR_BITS:0] lit_q, lit_d;
   logic               lit_hs;

   always_comb begin
      cnt_d  = cnt_q;
      lit_d  = lit_q;
      lit_hs = m_valid_q && m_ready && (m_pixel_q != '0);
      if (frame_tick) begin
         // A handshake on the tick cycle belongs to the new frame.
         lit_d = cnt_q;
         cnt_d = lit_hs ? (ADDR_BITS+1)'(1) : '0;
      end else if (lit_hs && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         lit_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lit_q <= lit_d;
      end
   end

   assign lit_count = lit_q;
`else
   assign lit_count = '0;
`endif

endmodule

// File: tb/tb_gfx_fade_rmw.sv
// -----------------------------------------------------------------------------
// tb_gfx_fade_rmw
//
// Directed self-checking bench for gfx_fade_rmw with default parameters
// (3 x 4-bit channels, 20-bit address, step 1, shift 2, period 4).
// Covers reset state, linear and proportional decay, frame phase gating,
// back-pressure ordering, mid-flight reset and (when GFX_FADE_RMW_STATS_EN is
// defined) the lit-pixel statistics.
// -----------------------------------------------------------------------------
module tb_gfx_fade_rmw;

   localparam int AB = 20;
   localparam int PB = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mode;
   logic          frame_tick;
   logic          s_valid;
   logic          s_ready;
   logic [AB-1:0] s_addr;
   logic [PB-1:0] s_pixel;
   logic          m_valid;
   logic          m_ready;
   logic [AB-1:0] m_addr;
   logic [PB-1:0] m_pixel;
   logic          m_write;
   logic [AB:0]   lit_count;

   int checks = 0;
   int errors = 0;

   gfx_fade_rmw dut (
      .clk        (clk),
      .reset      (rst_n),
      .mode       (mode),
      .frame_tick (frame_tick),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_addr     (s_addr),
      .s_pixel    (s_pixel),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_addr     (m_addr),
      .m_pixel    (m_pixel),
      .m_write    (m_write),
      .lit_count  (lit_count)
   );

   always #5 clk = ~clk;

   // Reference decay for a fade frame, written straight from the channel rules.
   function automatic logic [PB-1:0] ref_fade(input logic [PB-1:0] p, input logic prop);
      logic [PB-1:0] r;
      int v, d;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         v = int'(p[c*4 +: 4]);
         if (prop) begin
            d = v / 4;
            if (d == 0 && v > 0) d = 1;
         end else begin
            d = 1;
         end
         r[c*4 +: 4] = (v > d) ? 4'(v - d) : 4'd0;
      end
      return r;
   endfunction

   function automatic logic [PB-1:0] pattern(input int i);
      return PB'((i * 293 + 17) & 12'hFFF);
   endfunction

   task automatic do_reset();
      rst_n      = 1'b0;
      s_valid    = 1'b0;
      frame_tick = 1'b0;
      m_ready    = 1'b1;
      s_addr     = '0;
      s_pixel    = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic tick_only();
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
   endtask

   // Presents one beat on an idle pipeline with m_ready=1 and returns what was
   // seen: s_ready while presented, m_valid one and two edges after capture.
   task automatic one_beat(input logic [AB-1:0] a, input logic [PB-1:0] p, input logic tk,
                           output logic sr, output logic v1, output logic v2,
                           output logic [AB-1:0] oa, output logic [PB-1:0] op,
                           output logic ow);
      @(negedge clk);
      s_valid = 1'b1; s_addr = a; s_pixel = p; frame_tick = tk; m_ready = 1'b1;
      #1 sr = s_ready;
      @(posedge clk);
      #1 s_valid = 1'b0; frame_tick = 1'b0;
      @(negedge clk);
      v1 = m_valid;
      @(negedge clk);
      v2 = m_valid; oa = m_addr; op = m_pixel; ow = m_write;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      checks++; if (m_addr !== '0) begin errors++; $display("FAIL reset_m_addr got %h want 0", m_addr); end
      checks++; if (m_pixel !== '0) begin errors++; $display("FAIL reset_m_pixel got %h want 0", m_pixel); end
      checks++; if (m_write !== 1'b0) begin errors++; $display("FAIL reset_m_write got %b want 0", m_write); end
      checks++; if (lit_count !== '0) begin errors++; $display("FAIL reset_lit_count got %h want 0", lit_count); end
   endtask

   task automatic test_linear();
      logic [PB-1:0] in_p [3]  = '{12'h5A3, 12'h000, 12'h100};
      logic [PB-1:0] exp_p [3] = '{12'h492, 12'h000, 12'h000};
      logic          exp_w [3] = '{1'b1, 1'b0, 1'b1};
      logic sr, v1, v2, ow; logic [AB-1:0] oa; logic [PB-1:0] op;
      mode = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         one_beat(AB'(20'h10 + i), in_p[i], 1'b0, sr, v1, v2, oa, op, ow);
         checks++; if (sr !== 1'b1 || v1 !== 1'b0 || v2 !== 1'b1) begin errors++;
            $display("FAIL lin_latency[%0d] got sr/v1/v2 %b%b%b want 101", i, sr, v1, v2); end
         checks++; if (oa !== AB'(20'h10 + i)) begin errors++; $display("FAIL lin_addr[%0d] got %h want %h", i, oa, 20'h10 + i); end
         checks++; if (op !== exp_p[i]) begin errors++; $display("FAIL lin_pixel[%0d] got %h want %h", i, op, exp_p[i]); end
         checks++; if (ow !== exp_w[i]) begin errors++; $display("FAIL lin_write[%0d] got %b want %b", i, ow, exp_w[i]); end
      end
   endtask

   task automatic test_proportional();
      logic [PB-1:0] in_p [4]  = '{12'hF30, 12'h001, 12'h444, 12'hFFF};
      logic [PB-1:0] exp_p [4] = '{12'hC20, 12'h000, 12'h333, 12'hCCC};
      logic sr, v1, v2, ow; logic [AB-1:0] oa; logic [PB-1:0] op;
      mode = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         one_beat(AB'(20'h200 + i), in_p[i], 1'b0, sr, v1, v2, oa, op, ow);
         checks++; if (op !== exp_p[i]) begin errors++; $display("FAIL prop_pixel[%0d] got %h want %h", i, op, exp_p[i]); end
         checks++; if (ow !== 1'b1) begin errors++; $display("FAIL prop_write[%0d] got %b want 1", i, ow); end
      end
      mode = 1'b0;
   endtask

   task automatic test_period();
      // pre_tick: standalone tick before the beat; with_tick: tick on the beat cycle
      logic pre_tick [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic with_tick [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic fades [6]     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic sr, v1, v2, ow; logic [AB-1:0] oa; logic [PB-1:0] op;
      logic [PB-1:0] want;
      mode = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (pre_tick[i]) tick_only();
         one_beat(AB'(20'h300 + i), 12'h5A3, with_tick[i], sr, v1, v2, oa, op, ow);
         want = fades[i] ? 12'h492 : 12'h5A3;
         checks++; if (op !== want || ow !== fades[i]) begin errors++;
            $display("FAIL period_frame[%0d] got %h/%b want %h/%b", i, op, ow, want, fades[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0, rcvd = 0, cyc = 0;
      logic do_in, do_out, prev_stall;
      logic [AB-1:0] prev_addr;
      logic [PB-1:0] prev_pix, want;
      mode = 1'b0;
      do_reset();
      prev_stall = 1'b0; prev_addr = '0; prev_pix = '0;
      while (rcvd < 1000 && cyc < 6000) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         s_valid = (sent < 1000);
         s_addr  = AB'(sent);
         s_pixel = pattern(sent);
         #1;
         if (prev_stall) begin
            checks++; if (m_valid !== 1'b1 || m_addr !== prev_addr || m_pixel !== prev_pix) begin errors++;
               $display("FAIL bp_hold got %b/%h/%h want 1/%h/%h", m_valid, m_addr, m_pixel, prev_addr, prev_pix); end
         end
         checks++; if (s_ready !== ((sent - rcvd) < 2 || m_ready)) begin errors++;
            $display("FAIL bp_s_ready cyc %0d got %b held %0d m_ready %b", cyc, s_ready, sent - rcvd, m_ready); end
         do_in  = s_valid && s_ready;
         do_out = m_valid && m_ready;
         if (do_out) begin
            want = ref_fade(pattern(rcvd), 1'b0);
            checks++; if (m_addr !== AB'(rcvd) || m_pixel !== want || m_write !== (want != pattern(rcvd))) begin errors++;
               $display("FAIL bp_beat[%0d] got %h/%h/%b want %h/%h/%b", rcvd, m_addr, m_pixel, m_write,
                        rcvd, want, want != pattern(rcvd)); end
         end
         prev_stall = m_valid && !m_ready;
         prev_addr  = m_addr;
         prev_pix   = m_pixel;
         @(posedge clk);
         if (do_in)  sent++;
         if (do_out) rcvd++;
         cyc++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      checks++; if (rcvd != 1000 || sent != 1000) begin errors++;
         $display("FAIL bp_count got sent %0d rcvd %0d want 1000/1000", sent, rcvd); end
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got m_valid %b want 0", m_valid); end
   endtask

   task automatic test_reset_midflight();
      logic sr, v1, v2, ow; logic [AB-1:0] oa; logic [PB-1:0] op;
      mode = 1'b0;
      do_reset();
      tick_only();                 // move phase off 0 so reset must restore it
      @(negedge clk);
      m_ready = 1'b0; s_valid = 1'b1; s_addr = 20'hAAAAA; s_pixel = 12'h777;
      @(posedge clk);
      #1 s_addr = 20'hBBBBB; s_pixel = 12'h888;
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin errors++;
         $display("FAIL mid_full got m_valid %b s_ready %b want 1 0", m_valid, s_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0 || m_addr !== '0 || m_pixel !== '0 || m_write !== 1'b0 || s_ready !== 1'b1) begin errors++;
         $display("FAIL mid_async_reset got %b/%h/%h/%b/%b want 0/0/0/0/1", m_valid, m_addr, m_pixel, m_write, s_ready); end
      @(negedge clk);
      rst_n = 1'b1; m_ready = 1'b1;
      one_beat(20'h12345, 12'h5A3, 1'b0, sr, v1, v2, oa, op, ow);
      checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || oa !== 20'h12345 || op !== 12'h492 || ow !== 1'b1) begin errors++;
         $display("FAIL mid_fresh_beat got %b%b/%h/%h/%b want 01/12345/492/1", v1, v2, oa, op, ow); end
   endtask

   task automatic test_stats();
      logic [PB-1:0] pix [10] = '{12'h5A3, 12'h000, 12'hFFF, 12'h222, 12'h001,
                                  12'h333, 12'h0F0, 12'h111, 12'hABC, 12'h765};
      mode = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         s_valid = 1'b1; s_addr = AB'(i); s_pixel = pix[i];
         @(posedge clk);
      end
      #1 s_valid = 1'b0;
      repeat (3) @(negedge clk);
      tick_only();
      @(negedge clk);
`ifdef GFX_FADE_RMW_STATS_EN
      checks++; if (lit_count !== 21'd7) begin errors++; $display("FAIL stats_frame got %0d want 7", lit_count); end
      // Beat whose output handshake lands on the tick edge.
      s_valid = 1'b1; s_addr = 20'h77; s_pixel = 12'h5A3;
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      frame_tick = 1'b1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stats_tick_align got m_valid %b want 1", m_valid); end
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
      checks++; if (lit_count !== 21'd0) begin errors++; $display("FAIL stats_tick_old got %0d want 0", lit_count); end
      tick_only();
      @(negedge clk);
      checks++; if (lit_count !== 21'd1) begin errors++; $display("FAIL stats_tick_new got %0d want 1", lit_count); end
`else
      checks++; if (lit_count !== '0) begin errors++; $display("FAIL stats_off got %0d want 0", lit_count); end
`endif
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; frame_tick = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      s_addr = '0; s_pixel = '0;
      test_reset();
      test_linear();
      test_proportional();
      test_period();
      test_back_to_back();
      test_reset_midflight();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
